// File: rtl/shared_data_mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// data_mem_pkg
// Shared definitions for the multi-core shared data memory:
//   - default channel count, address width and word width
//   - idx_width(): width of a core index ($clog2(n), never below 1)
//   - even_parity(): parity bit that makes the stored word even
// Build option: DATAMEM_PARITY_EN (read by the top module, not by this package).
// ---------------------------------------------------------------------------
package data_mem_pkg;

   localparam int DEF_NCORES = 2;
   localparam int DEF_LMEM   = 8;
   localparam int DEF_TAM    = 16;

   // A single core still needs a one-bit index so that ports never collapse to zero width.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Parity bit that makes {parity, data} contain an even number of ones.
   function automatic logic even_parity(input logic [63:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/shared_data_mem_arb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Round-robin selection of one eligible requester per cycle. The search starts
// at the pointer and wraps; after a grant to g the pointer moves to (g+1) mod N.
// Ports:
//   clk          in   clock
//   rst          in   synchronous active-high reset (pointer back to 0)
//   i_req        in   N request lines
//   i_mask       in   N lines; a set bit makes that requester ineligible
//   o_grant      out  one-hot grant (all zero when nothing eligible)
//   o_grant_idx  out  index of the granted requester
//   o_valid      out  a grant is issued this cycle
// ---------------------------------------------------------------------------
module rr_arbiter
   import data_mem_pkg::*;
#(
   parameter int N = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [N-1:0]               i_req,
   input  logic [N-1:0]               i_mask,
   output logic [N-1:0]               o_grant,
   output logic [idx_width(N)-1:0]    o_grant_idx,
   output logic                       o_valid
);

   localparam int IW = idx_width(N);

   logic [IW-1:0] r_ptr;
   logic [N-1:0]  w_elig;

   // Index 'ofs' places after pointer position 'p', wrapped into 0..N-1.
   function automatic logic [IW-1:0] wrap_idx(input int p, input int ofs);
      return IW'((p + ofs) % N);
   endfunction

   // First eligible requester at or after the pointer wins.
   always_comb begin
      w_elig      = i_req & ~i_mask;
      o_grant     = '0;
      o_grant_idx = '0;
      o_valid     = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (!o_valid && w_elig[wrap_idx(int'(r_ptr), i)]) begin
            o_valid                            = 1'b1;
            o_grant_idx                        = wrap_idx(int'(r_ptr), i);
            o_grant[wrap_idx(int'(r_ptr), i)]  = 1'b1;
         end else begin
            o_valid = o_valid;
         end
      end
   end

   // Pointer moves just past the winner so the winner becomes lowest priority.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr <= '0;
      end else if (o_valid) begin
         r_ptr <= wrap_idx(int'(o_grant_idx), 1);
      end else begin
         r_ptr <= r_ptr;
      end
   end

endmodule

// File: rtl/shared_data_mem_arb.sv
// ---------------------------------------------------------------------------
// shared_data_mem_arb
// NCORES cores share one single-port word array through a round-robin arbiter.
// One access completes per cycle; a granted access executes on the edge that
// ends the grant cycle, dataReady pulses in the following cycle together with
// the read data. A core is masked from arbitration while its dataReady is high,
// so a held request cannot be served twice.
// Ports:
//   clk        in   clock
//   rst        in   synchronous active-high reset
//   dataIN     in   write data, core c at [c*TAM +: TAM]
//   dataADDR   in   word address, core c at [c*TAM +: TAM]; bits >= LMEM ignored
//   dataLoad   in   read request per core (level)
//   dataWrite  in   write request per core (level)
//   dataOUT    out  registered read data per core (held until next read)
//   dataReady  out  one-cycle completion pulse per core
//   dataErr    out  parity error on the completing read
// Build option DATAMEM_PARITY_EN: array stores an even-parity bit per word and
// dataErr reports mismatches; without it dataErr is constant 0.
// ---------------------------------------------------------------------------
module shared_data_mem_arb
   import data_mem_pkg::*;
#(
   parameter int NCORES = DEF_NCORES,
   parameter int LMEM   = DEF_LMEM,
   parameter int TAM    = DEF_TAM
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NCORES*TAM-1:0]   dataIN,
   input  logic [NCORES*TAM-1:0]   dataADDR,
   input  logic [NCORES-1:0]       dataLoad,
   input  logic [NCORES-1:0]       dataWrite,
   output logic [NCORES*TAM-1:0]   dataOUT,
   output logic [NCORES-1:0]       dataReady,
   output logic [NCORES-1:0]       dataErr
);

   localparam int IW    = idx_width(NCORES);
   localparam int DEPTH = 1 << LMEM;
`ifdef DATAMEM_PARITY_EN
   localparam int MW    = TAM + 1;
`else
   localparam int MW    = TAM;
`endif

   logic [MW-1:0]          r_mem [0:DEPTH-1];
   logic [NCORES*TAM-1:0]  r_out;
   logic [NCORES-1:0]      r_ready;

   logic [NCORES-1:0]      w_req;
   logic [NCORES-1:0]      w_grant;
   logic [IW-1:0]          w_idx;
   logic                   w_valid;
   logic [TAM-1:0]         w_addr;
   logic [LMEM-1:0]        w_maddr;
   logic [TAM-1:0]         w_wdata;
   logic [MW-1:0]          w_wword;
   logic [MW-1:0]          w_rword;
   logic                   w_ld;
   logic                   w_wr;

   assign w_req = dataLoad | dataWrite;

   rr_arbiter #(
      .N (NCORES)
   ) u_arb (
      .clk         (clk),
      .rst         (rst),
      .i_req       (w_req),
      .i_mask      (r_ready),
      .o_grant     (w_grant),
      .o_grant_idx (w_idx),
      .o_valid     (w_valid)
   );

   // Route the winner's address, data and access type to the array.
   assign w_addr  = dataADDR[w_idx*TAM +: TAM];
   assign w_wdata = dataIN[w_idx*TAM +: TAM];
   assign w_ld    = dataLoad[w_idx];
   assign w_wr    = dataWrite[w_idx];
   assign w_maddr = w_addr[LMEM-1:0];
   assign w_rword = r_mem[w_maddr];

   // Upper address bits alias onto the array and carry no meaning.
   if (TAM > LMEM) begin : g_addr_hi
      logic w_unused_addr_hi;
      assign w_unused_addr_hi = ^w_addr[TAM-1:LMEM];
   end

`ifdef DATAMEM_PARITY_EN
   logic [NCORES-1:0] r_err;
   assign w_wword = {even_parity(64'(w_wdata)), w_wdata};
   assign dataErr = r_err;

   // Parity pulse accompanies the completing read; data is returned regardless.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_err <= '0;
      end else begin
         r_err <= '0;
         if (w_valid && w_ld) begin
            r_err[w_idx] <= even_parity(64'(w_rword[TAM-1:0])) ^ w_rword[TAM];
         end
      end
   end
`else
   assign w_wword = w_wdata;
   assign dataErr = '0;
`endif

   // Array write port; contents are not reset and a reset edge suppresses the access.
   always_ff @(posedge clk) begin
      if (!rst && w_valid && w_wr) begin
         r_mem[w_maddr] <= w_wword;
      end
   end

   // Completion pulse and read data; a load+write returns the pre-write word.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out   <= '0;
         r_ready <= '0;
      end else begin
         r_ready <= w_grant;
         if (w_valid && w_ld) begin
            r_out[w_idx*TAM +: TAM] <= w_rword[TAM-1:0];
         end
      end
   end

   assign dataOUT   = r_out;
   assign dataReady = r_ready;

endmodule

// File: tb/tb_shared_data_mem_arb.sv
// Self-checking bench for shared_data_mem_arb with four cores.
module tb_shared_data_mem_arb;

   localparam int NC = 4;
   localparam int LM = 8;
   localparam int TW = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic [NC*TW-1:0]  din_bus;
   logic [NC*TW-1:0]  addr_bus;
   logic [NC-1:0]     ld;
   logic [NC-1:0]     wr;
   logic [NC*TW-1:0]  dataOUT;
   logic [NC-1:0]     dataReady;
   logic [NC-1:0]     dataErr;

   logic [TW-1:0]     din_a  [NC];
   logic [TW-1:0]     addr_a [NC];

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state for the randomized phase.
   logic [TW-1:0]     mem_m [256];
   bit                vld_m [256];
   logic [TW-1:0]     exp_out [NC];
   bit                known [NC];
   bit                pend [NC];
   logic [NC-1:0]     exp_ready;
   int                ptr_m;

   typedef struct {
      int          core;
      logic        l;
      logic        w;
      logic [15:0] addr;
      logic [15:0] data;
      logic [15:0] exp;
   } vec_t;
   vec_t vecs [9];

   shared_data_mem_arb #(.NCORES(NC), .LMEM(LM), .TAM(TW)) dut (
      .clk       (clk),
      .rst       (rst),
      .dataIN    (din_bus),
      .dataADDR  (addr_bus),
      .dataLoad  (ld),
      .dataWrite (wr),
      .dataOUT   (dataOUT),
      .dataReady (dataReady),
      .dataErr   (dataErr)
   );

   always #5 clk = ~clk;

   always_comb begin
      din_bus  = '0;
      addr_bus = '0;
      for (int c = 0; c < NC; c++) begin
         din_bus[c*TW +: TW]  = din_a[c];
         addr_bus[c*TW +: TW] = addr_a[c];
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // One uncontended access: ready exactly one cycle after the request.
   task automatic txn(input int c, input logic l, input logic w,
                      input logic [15:0] a, input logic [15:0] d, input logic [15:0] exp);
      ld[c] = l; wr[c] = w; addr_a[c] = a; din_a[c] = d;
      step;
      chk("txn_ready", 32'(dataReady), 32'(1) << c);
      chk("txn_out", 32'(dataOUT[c*TW +: TW]), 32'(exp));
      chk("txn_err", 32'(dataErr), 32'd0);
      ld[c] = 1'b0; wr[c] = 1'b0;
      step;
      chk("txn_idle", 32'(dataReady), 32'd0);
   endtask

   task automatic pulse_rst;
      rst = 1'b1;
      step;
      rst = 1'b0;
   endtask

   initial begin
      vecs[0] = '{0, 1'b0, 1'b1, 16'h0005, 16'h1234, 16'h0000};
      vecs[1] = '{0, 1'b1, 1'b0, 16'h0005, 16'h0000, 16'h1234};
      vecs[2] = '{0, 1'b0, 1'b1, 16'h0020, 16'h1111, 16'h1234};
      vecs[3] = '{0, 1'b1, 1'b1, 16'h0020, 16'h0F0F, 16'h1111};
      vecs[4] = '{0, 1'b1, 1'b0, 16'h0020, 16'h0000, 16'h0F0F};
      vecs[5] = '{0, 1'b1, 1'b0, 16'h0105, 16'h0000, 16'h1234};
      vecs[6] = '{2, 1'b0, 1'b1, 16'h01FF, 16'h7777, 16'h0000};
      vecs[7] = '{3, 1'b1, 1'b0, 16'h00FF, 16'h0000, 16'h7777};
      vecs[8] = '{1, 1'b1, 1'b0, 16'h0005, 16'h0000, 16'h1234};

      rst = 1'b1; ld = '0; wr = '0;
      for (int c = 0; c < NC; c++) begin
         din_a[c] = '0; addr_a[c] = '0;
      end
      step; step;
      chk("rst_ready", 32'(dataReady), 32'd0);
      chk("rst_out", 32'(dataOUT[31:0]), 32'd0);
      chk("rst_out_hi", 32'(dataOUT[63:32]), 32'd0);
      chk("rst_err", 32'(dataErr), 32'd0);
      rst = 1'b0;
      step;

      // Single-core vectors: write/read, unchanged on write, read-before-write, alias.
      for (int i = 0; i < 9; i++) begin
         txn(vecs[i].core, vecs[i].l, vecs[i].w, vecs[i].addr, vecs[i].data, vecs[i].exp);
      end

      // Two simultaneous writes after reset: core0 first, core1 next cycle.
      pulse_rst;
      ld[0] = 1'b0; wr[0] = 1'b1; addr_a[0] = 16'h0010; din_a[0] = 16'hAAAA;
      ld[1] = 1'b0; wr[1] = 1'b1; addr_a[1] = 16'h0011; din_a[1] = 16'h5555;
      step;
      chk("dual_first", 32'(dataReady), 32'h1);
      wr[0] = 1'b0;
      step;
      chk("dual_second", 32'(dataReady), 32'h2);
      wr[1] = 1'b0;
      step;
      txn(0, 1'b1, 1'b0, 16'h0010, 16'h0000, 16'hAAAA);
      txn(1, 1'b1, 1'b0, 16'h0011, 16'h0000, 16'h5555);

      // One core holding its request: served at most every other cycle.
      ld[0] = 1'b1; addr_a[0] = 16'h0010;
      for (int i = 0; i < 6; i++) begin
         step;
         chk("held_rate", 32'(dataReady), (i % 2 == 0) ? 32'h1 : 32'h0);
      end
      ld[0] = 1'b0;
      step; step;

      // All cores requesting continuously: strict rotation from pointer 0.
      pulse_rst;
      for (int c = 0; c < NC; c++) begin
         ld[c] = 1'b1; addr_a[c] = 16'h0010;
      end
      for (int i = 0; i < 8; i++) begin
         step;
         chk("rotate", 32'(dataReady), 32'(1) << (i % 4));
      end
      ld = '0;
      step; step;

      // Reset during a pending write: suppressed, then re-arbitrated from pointer 0.
      ld[1] = 1'b0; wr[1] = 1'b1; addr_a[1] = 16'h0105; din_a[1] = 16'hBEEF;
      rst = 1'b1;
      step;
      chk("rst_pending", 32'(dataReady), 32'd0);
      rst = 1'b0;
      ld[0] = 1'b1; wr[0] = 1'b0; addr_a[0] = 16'h0005;
      step;
      chk("after_rst_ready", 32'(dataReady), 32'h1);
      chk("after_rst_old", 32'(dataOUT[15:0]), 32'h1234);
      ld[0] = 1'b0;
      step;
      chk("pending_done", 32'(dataReady), 32'h2);
      wr[1] = 1'b0;
      step;
      txn(0, 1'b1, 1'b0, 16'h0005, 16'h0000, 16'hBEEF);

`ifdef DATAMEM_PARITY_EN
      txn(0, 1'b0, 1'b1, 16'h0030, 16'h0003, 16'hBEEF);
      dut.r_mem[8'h30] = dut.r_mem[8'h30] ^ 17'h00001;
      ld[0] = 1'b1; addr_a[0] = 16'h0030;
      step;
      chk("par_err", 32'(dataErr), 32'h1);
      chk("par_ready", 32'(dataReady), 32'h1);
      ld[0] = 1'b0;
      step;
      txn(0, 1'b1, 1'b0, 16'h0005, 16'h0000, 16'hBEEF);
`endif

      // Randomized traffic against the round-robin reference model.
      pulse_rst;
      ptr_m = 0;
      exp_ready = '0;
      for (int a = 0; a < 256; a++) vld_m[a] = 1'b0;
      for (int c = 0; c < NC; c++) begin
         exp_out[c] = '0; known[c] = 1'b1; pend[c] = 1'b0;
      end
      for (int cyc = 0; cyc < 400; cyc++) begin
         int g;
         chk("rand_ready", 32'(dataReady), 32'(exp_ready));
         chk("rand_err", 32'(dataErr), 32'd0);
         for (int c = 0; c < NC; c++) begin
            if (known[c]) chk("rand_out", 32'(dataOUT[c*TW +: TW]), 32'(exp_out[c]));
         end
         for (int c = 0; c < NC; c++) begin
            if (exp_ready[c]) begin
               ld[c] = 1'b0; wr[c] = 1'b0; pend[c] = 1'b0;
            end else if (!pend[c] && ($urandom % 3 == 0)) begin
               int kind;
               kind = $urandom_range(1, 3);
               ld[c] = ((kind & 1) != 0);
               wr[c] = ((kind & 2) != 0);
               addr_a[c] = {8'($urandom_range(0, 255)), 8'h40 + 8'($urandom_range(0, 7))};
               din_a[c] = 16'($urandom);
               pend[c] = 1'b1;
            end
         end
         g = -1;
         for (int i = 0; i < NC; i++) begin
            if (g < 0 && pend[(ptr_m + i) % NC]) g = (ptr_m + i) % NC;
         end
         exp_ready = '0;
         if (g >= 0) begin
            int a;
            a = int'(addr_a[g][7:0]);
            exp_ready[g] = 1'b1;
            if (ld[g]) begin
               exp_out[g] = mem_m[a];
               known[g] = vld_m[a];
            end
            if (wr[g]) begin
               mem_m[a] = din_a[g];
               vld_m[a] = 1'b1;
            end
            ptr_m = (g + 1) % NC;
         end
         step;
      end
      ld = '0; wr = '0;
      step; step;

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
